// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } mem_state_e;

  // Younger producer (M) wins over older (W); $0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wr_m,
    input logic       rw_m,
    input logic [4:0] wr_w,
    input logic       rw_w
  );
    if (rw_m && (wr_m != 5'd0) && (wr_m == src))
      return FWD_M;
    else if (rw_w && (wr_w != 5'd0) && (wr_w == src))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// rtl/hazard_mem_fsm.sv - data-memory handshake sequencer with wait counter and sticky timeout
module hazard_mem_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TCNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_access_M,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic mem_stall,
  output logic mem_err
);

  mem_state_e        state, state_next;
  logic [TCNT_W-1:0] count, count_next;
  logic              err_q, err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MEM_IDLE;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      err_q <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    err_next   = err_q;
    case (state)
      MEM_IDLE: begin
        if (mem_access_M && !dmem_ready) begin
          state_next = MEM_WAIT;
          count_next = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = MEM_IDLE;
        end else if (count == TCNT_W'(MEM_TIMEOUT - 1)) begin
          state_next = MEM_ERR;
          err_next   = 1'b1;
        end else begin
          count_next = count + TCNT_W'(1);
        end
      end
      MEM_ERR: begin
        state_next = MEM_ERR;
      end
      default: begin
        state_next = MEM_IDLE;
      end
    endcase
  end

  // Outputs are forced low during reset so an abandoned access drops its request immediately.
  assign dmem_req  = !rst && mem_access_M && (state != MEM_ERR);
  assign mem_stall = !rst && ((mem_access_M && !dmem_ready && (state != MEM_ERR)) ||
                              (state == MEM_ERR));
  assign mem_err   = !rst && err_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall/flush priority and memory freeze control
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TCNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] write_reg_E,
  input  logic       reg_write_E,
  input  logic       mem_to_reg_E,
  input  logic [4:0] write_reg_M,
  input  logic       reg_write_M,
  input  logic [4:0] write_reg_W,
  input  logic       reg_write_W,
  input  logic       pc_src_M,
  input  logic       mem_access_M,
  input  logic       dmem_ready,
  output logic [1:0] forward_a_E,
  output logic [1:0] forward_b_E,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       stall_M,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_W,
  output logic       dmem_req,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_evt
`endif
);

  logic mem_stall;
  logic load_use;

  hazard_mem_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TCNT_W      (TCNT_W)
  ) u_mem_fsm (
    .clk          (clk),
    .rst          (rst),
    .mem_access_M (mem_access_M),
    .dmem_ready   (dmem_ready),
    .dmem_req     (dmem_req),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err)
  );

  always_comb begin
    forward_a_E = FWD_RF;
    forward_b_E = FWD_RF;
    if (!rst) begin
      forward_a_E = fwd_sel(rs_E, write_reg_M, reg_write_M, write_reg_W, reg_write_W);
      forward_b_E = fwd_sel(rt_E, write_reg_M, reg_write_M, write_reg_W, reg_write_W);
    end
  end

  assign load_use = reg_write_E && mem_to_reg_E && (write_reg_E != 5'd0) &&
                    ((write_reg_E == rs_D) || (write_reg_E == rt_D));

  // Memory freeze dominates; a branch held in frozen M fires once the freeze lifts.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (pc_src_M) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_evt <= '0;
    end else begin
      if (stall_F)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (pc_src_M && !mem_stall)
        perf_flush_evt <= perf_flush_evt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs_D = '0, rt_D = '0, rs_E = '0, rt_E = '0;
  logic [4:0] write_reg_E = '0, write_reg_M = '0, write_reg_W = '0;
  logic       reg_write_E = 1'b0, mem_to_reg_E = 1'b0, reg_write_M = 1'b0, reg_write_W = 1'b0;
  logic       pc_src_M = 1'b0, mem_access_M = 1'b0, dmem_ready = 1'b0;
  logic [1:0] forward_a_E, forward_b_E;
  logic       stall_F, stall_D, stall_E, stall_M;
  logic       flush_D, flush_E, flush_W, dmem_req, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_evt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(15), .TCNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs_D         (rs_D),
    .rt_D         (rt_D),
    .rs_E         (rs_E),
    .rt_E         (rt_E),
    .write_reg_E  (write_reg_E),
    .reg_write_E  (reg_write_E),
    .mem_to_reg_E (mem_to_reg_E),
    .write_reg_M  (write_reg_M),
    .reg_write_M  (reg_write_M),
    .write_reg_W  (write_reg_W),
    .reg_write_W  (reg_write_W),
    .pc_src_M     (pc_src_M),
    .mem_access_M (mem_access_M),
    .dmem_ready   (dmem_ready),
    .forward_a_E  (forward_a_E),
    .forward_b_E  (forward_b_E),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .stall_E      (stall_E),
    .stall_M      (stall_M),
    .flush_D      (flush_D),
    .flush_E      (flush_E),
    .flush_W      (flush_W),
    .dmem_req     (dmem_req),
    .mem_err      (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_evt (perf_flush_evt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_D = '0; rt_D = '0; rs_E = '0; rt_E = '0;
    write_reg_E = '0; write_reg_M = '0; write_reg_W = '0;
    reg_write_E = 1'b0; mem_to_reg_E = 1'b0; reg_write_M = 1'b0; reg_write_W = 1'b0;
    pc_src_M = 1'b0; mem_access_M = 1'b0; dmem_ready = 1'b0;
  endtask

  // Packs the stall/flush vector as {F,D,E,M,flushD,flushE,flushW}
  function automatic logic [6:0] ctl();
    return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};
  endfunction

  initial begin
    // Reset with hazards present on every input: all outputs must be 0
    @(negedge clk);
    rs_E = 5'd8; write_reg_M = 5'd8; reg_write_M = 1'b1;
    reg_write_E = 1'b1; mem_to_reg_E = 1'b1; write_reg_E = 5'd9; rt_D = 5'd9;
    pc_src_M = 1'b1; mem_access_M = 1'b1; dmem_ready = 1'b0;
    #1;
    check("rst_fwd_a", 32'(forward_a_E), 32'd0);
    check("rst_ctl", 32'(ctl()), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);

    // Forwarding: M beats W on $8
    @(negedge clk);
    rst = 1'b0; clear_inputs();
    rs_E = 5'd8; rt_E = 5'd3;
    reg_write_M = 1'b1; write_reg_M = 5'd8;
    reg_write_W = 1'b1; write_reg_W = 5'd8;
    #1;
    check("fwd_m_prio", 32'(forward_a_E), 32'h2);
    check("fwd_b_none", 32'(forward_b_E), 32'h0);
    check("fwd_no_ctl", 32'(ctl()), 32'd0);

    // write_reg_M = 0 falls through to W match
    @(negedge clk);
    write_reg_M = 5'd0;
    #1;
    check("fwd_w_fallback", 32'(forward_a_E), 32'h1);

    // Register 0 never forwarded from either stage
    @(negedge clk);
    rs_E = 5'd0; write_reg_W = 5'd0;
    rt_E = 5'd8; reg_write_M = 1'b0; write_reg_M = 5'd8;
    #1;
    check("fwd_r0_a", 32'(forward_a_E), 32'h0);
    check("fwd_b_wr_disabled", 32'(forward_b_E), 32'h0);

    // Load-use: lw $9 in E, D reads rt=9
    @(negedge clk);
    clear_inputs();
    reg_write_E = 1'b1; mem_to_reg_E = 1'b1; write_reg_E = 5'd9; rt_D = 5'd9;
    #1;
    check("load_use_ctl", 32'(ctl()), 32'b1100010);

    // Next cycle the load sits in W and the consumer is in E
    @(negedge clk);
    clear_inputs();
    rt_E = 5'd9; reg_write_W = 1'b1; write_reg_W = 5'd9;
    #1;
    check("load_use_fwd_w", 32'(forward_b_E), 32'h1);
    check("load_use_released", 32'(ctl()), 32'd0);

    // Load to $0 is not a hazard
    @(negedge clk);
    clear_inputs();
    reg_write_E = 1'b1; mem_to_reg_E = 1'b1; write_reg_E = 5'd0; rs_D = 5'd0;
    #1;
    check("load_r0_no_stall", 32'(ctl()), 32'd0);

    // Branch taken together with load-use: flush D/E only
    @(negedge clk);
    clear_inputs();
    reg_write_E = 1'b1; mem_to_reg_E = 1'b1; write_reg_E = 5'd9; rs_D = 5'd9;
    pc_src_M = 1'b1;
    #1;
    check("branch_over_lu", 32'(ctl()), 32'b0000110);

    // Memory access with ready low for 3 cycles; branch held in M is suppressed
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      mem_access_M = 1'b1; dmem_ready = 1'b0; pc_src_M = 1'b1;
      #1;
      check($sformatf("memwait_ctl_%0d", i), 32'(ctl()), 32'b1111001);
      check($sformatf("memwait_req_%0d", i), 32'(dmem_req), 32'd1);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    check("memdone_req", 32'(dmem_req), 32'd1);
    check("memdone_branch_flush", 32'(ctl()), 32'b0000110);
    @(negedge clk);
    clear_inputs();
    #1;
    check("mem_idle_req", 32'(dmem_req), 32'd0);
    check("mem_idle_ctl", 32'(ctl()), 32'd0);

    // Zero-wait access: no stall, request visible
    @(negedge clk);
    mem_access_M = 1'b1; dmem_ready = 1'b1;
    #1;
    check("zero_wait_ctl", 32'(ctl()), 32'd0);
    check("zero_wait_req", 32'(dmem_req), 32'd1);

    // Timeout: 1 IDLE cycle + 15 WAIT cycles before ERR
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clear_inputs();
      mem_access_M = 1'b1; dmem_ready = 1'b0;
      #1;
      if (i == 0 || i == 15) begin
        check($sformatf("to_err_low_%0d", i), 32'(mem_err), 32'd0);
        check($sformatf("to_req_%0d", i), 32'(dmem_req), 32'd1);
      end
    end
    @(negedge clk);
    #1;
    check("err_set", 32'(mem_err), 32'd1);
    check("err_req_drop", 32'(dmem_req), 32'd0);
    check("err_ctl", 32'(ctl()), 32'b1111001);
    @(negedge clk);
    clear_inputs(); dmem_ready = 1'b1; pc_src_M = 1'b1;
    #1;
    check("err_sticky", 32'(mem_err), 32'd1);
    check("err_still_stall", 32'(ctl()), 32'b1111001);

    // Reset pulse clears ERR
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_err_ctl", 32'(ctl()), 32'd0);
    check("rst_in_err_flag", 32'(mem_err), 32'd0);
    @(negedge clk);
    rst = 1'b0; clear_inputs();
    #1;
    check("post_rst_ctl", 32'(ctl()), 32'd0);
    check("post_rst_err", 32'(mem_err), 32'd0);

    // Reset during WAIT abandons the access
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_access_M = 1'b1; dmem_ready = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0; dmem_ready = 1'b1;
    #1;
    check("rst_wait_idle", 32'(ctl()), 32'd0);

    // Perf scenario from a clean reset: 3-cycle stall then one taken branch
    @(negedge clk);
    rst = 1'b1; clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    mem_access_M = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    dmem_ready = 1'b1;
    @(negedge clk);
    clear_inputs(); pc_src_M = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    check("perf_scn_quiet", 32'(ctl()), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_cyc", perf_stall_cyc, 32'd3);
    check("perf_flush_evt", perf_flush_evt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
